// File: rtl/tm1638_pkg.sv
// Shared definitions for the TM1638 display path: segment codes, limits and formatter FSM states.
// The tm1638 driver imports this package as well.
package tm1638_pkg;

  localparam logic [7:0]  SEG_BLANK   = 8'h00;
  localparam logic [7:0]  SEG_DASH    = 8'h40;
  localparam logic [26:0] DEC_MAX     = 27'd99_999_999;
  localparam logic [2:0]  FIRST_DIGIT = 3'd0;
  localparam logic [2:0]  LAST_DIGIT  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_ENC  = 2'd2,
    ST_UPD  = 2'd3
  } fmt_state_e;

  // Nibble to segment code; bit0..6 = a..g, bit7 (dp) always clear here.
  function automatic logic [7:0] seg7_code(input logic [3:0] nib);
    logic [7:0] code;
    case (nib)
      4'h0:    code = 8'h3F;
      4'h1:    code = 8'h06;
      4'h2:    code = 8'h5B;
      4'h3:    code = 8'h4F;
      4'h4:    code = 8'h66;
      4'h5:    code = 8'h6D;
      4'h6:    code = 8'h7D;
      4'h7:    code = 8'h07;
      4'h8:    code = 8'h7F;
      4'h9:    code = 8'h6F;
      4'hA:    code = 8'h77;
      4'hB:    code = 8'h7C;
      4'hC:    code = 8'h39;
      4'hD:    code = 8'h5E;
      4'hE:    code = 8'h79;
      4'hF:    code = 8'h71;
      default: code = 8'h00;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/tm1638_display_fmt_bin2bcd_seq.sv
// Sequential double-dabble: one add-3/shift step per clock, VAL_W steps after the start edge.
module bin2bcd_seq #(
  parameter int VAL_W = 27
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [VAL_W-1:0] value_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [31:0]      bcd_o
);

  localparam int CNT_W = $clog2(VAL_W + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(VAL_W - 1);

  logic [VAL_W+31:0] shift_q;
  logic [VAL_W+31:0] adj_s;
  logic [CNT_W-1:0]  cnt_q;
  logic              busy_q;

  // Add 3 to every BCD nibble >= 5 ahead of the shift; 4-bit add, carry dropped.
  always_comb begin
    adj_s = shift_q;
    for (int k = 0; k < 8; k++) begin
      if (shift_q[VAL_W+4*k +: 4] >= 4'd5) begin
        adj_s[VAL_W+4*k +: 4] = shift_q[VAL_W+4*k +: 4] + 4'd3;
      end else begin
        adj_s[VAL_W+4*k +: 4] = shift_q[VAL_W+4*k +: 4];
      end
    end
  end

  // Load on start, then shift {bcd, bin} left once per cycle until the last step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else if (start_i && !busy_q) begin
      shift_q <= {32'd0, value_i};
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else if (busy_q) begin
      shift_q <= {adj_s[VAL_W+30:0], 1'b0};
      cnt_q   <= cnt_q + CNT_W'(1);
      if (cnt_q == LAST_STEP) begin
        busy_q <= 1'b0;
      end else begin
        busy_q <= 1'b1;
      end
    end else begin
      shift_q <= shift_q;
    end
  end

  // done marks the cycle whose closing edge performs the final shift, so the
  // sequencer can leave CONV on that same edge with bcd_o valid right after it.
  assign done_o = busy_q && (cnt_q == LAST_STEP);
  assign busy_o = busy_q;
  assign bcd_o  = shift_q[VAL_W +: 32];

endmodule

// File: rtl/tm1638_display_fmt.sv
// Formats a binary value into eight 7-seg codes for the tm1638 driver; seg updates on a single edge.
module tm1638_display_fmt
  import tm1638_pkg::*;
#(
  parameter int VAL_W     = 27,
  parameter bit DEF_BLANK = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [VAL_W-1:0] value_i,
  input  logic             hex_mode_i,
  input  logic             blank_lz_i,
  input  logic [7:0]       dp_mask_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             overflow_o,
  output logic [63:0]      seg_o
);

  fmt_state_e  state_q, state_d;
  logic        busy_q, done_q, ovf_q, hex_q, lz_q;
  logic [7:0]  dp_q;
  logic [2:0]  idx_q;
  logic [31:0] nib_q;
  logic [63:0] shadow_q, seg_q;

  logic        ovf_in_s, eng_start_s, eng_busy_s, eng_done_s;
  logic [31:0] bcd_s, src_s;
  logic [3:0]  enc_nib_s;
  logic [7:0]  raw_code_s, enc_code_s;

  assign ovf_in_s    = !hex_mode_i && (32'(value_i) > 32'(DEC_MAX));
  assign eng_start_s = (state_q == ST_IDLE) && start_i && !hex_mode_i && !ovf_in_s;

  bin2bcd_seq #(.VAL_W(VAL_W)) u_bin2bcd (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (eng_start_s),
    .value_i (value_i),
    .busy_o  (eng_busy_s),
    .done_o  (eng_done_s),
    .bcd_o   (bcd_s)
  );

  // Digit encoder: picks digit idx_q (digit 0 = most significant nibble) and applies blanking/dash/dp.
  always_comb begin
    if (hex_q) begin
      src_s = nib_q;
    end else begin
      src_s = bcd_s;
    end
    enc_nib_s = src_s[{~idx_q, 2'b00} +: 4];
    if (ovf_q) begin
      raw_code_s = SEG_DASH;
    end else if (lz_q && (enc_nib_s == 4'd0) && (idx_q != LAST_DIGIT)) begin
      raw_code_s = SEG_BLANK;
    end else begin
      raw_code_s = seg7_code(enc_nib_s);
    end
    enc_code_s = raw_code_s | {dp_q[idx_q], 7'b0000000};
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i && (hex_mode_i || ovf_in_s)) begin
          state_d = ST_ENC;
        end else if (start_i) begin
          state_d = ST_CONV;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CONV: begin
        if (eng_done_s || !eng_busy_s) begin
          state_d = ST_ENC;
        end else begin
          state_d = ST_CONV;
        end
      end
      ST_ENC: begin
        if (idx_q == LAST_DIGIT) begin
          state_d = ST_UPD;
        end else begin
          state_d = ST_ENC;
        end
      end
      ST_UPD:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Input latching on the accepted start, shadow build in ENC, single-edge seg publish in UPD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      hex_q    <= 1'b0;
      lz_q     <= DEF_BLANK;
      dp_q     <= 8'h00;
      idx_q    <= FIRST_DIGIT;
      nib_q    <= 32'd0;
      shadow_q <= 64'd0;
      seg_q    <= 64'd0;
    end else begin
      done_q <= (state_q == ST_UPD);
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            busy_q <= 1'b1;
            ovf_q  <= ovf_in_s;
            hex_q  <= hex_mode_i;
            lz_q   <= blank_lz_i;
            dp_q   <= dp_mask_i;
            idx_q  <= FIRST_DIGIT;
            nib_q  <= 32'(value_i);
          end else begin
            busy_q <= 1'b0;
          end
        end
        ST_CONV: begin
          busy_q <= 1'b1;
        end
        ST_ENC: begin
          shadow_q[{idx_q, 3'b000} +: 8] <= enc_code_s;
          idx_q <= idx_q + 3'd1;
          if (enc_nib_s != 4'd0) begin
            lz_q <= 1'b0;
          end else begin
            lz_q <= lz_q;
          end
        end
        ST_UPD: begin
          seg_q  <= shadow_q;
          busy_q <= 1'b0;
        end
        default: begin
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign overflow_o = ovf_q;
  assign seg_o      = seg_q;

endmodule
